systolic_ctrl: RTL and testbench
================================

# systolic_ctrl

Sequencer for one DIM×DIM systolic MAC array. On `start` it runs four phases in order:
- zero the accumulators row by row;
- accept DIM operand slices through a valid/ready stream, applying the per-lane skew the array needs;
- flush the pipeline with zeros;
- read the result matrix out row by row through a valid/ready stream.

It sits between the host-facing operand/result buffers and the array, and owns every array control input (`en`, `WrEn`, `Crow`, `A`, `B`, `Cin`).

## Interface
- `BITS_AB`, default 8: signed operand width.
- `BITS_C`, default 16: signed accumulator width.
- `DIM`, default 8: array dimension and inner (K) dimension, ≥2.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  begin a job; sampled only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last result row is accepted.
- `op_valid`  in  1  operand slice present.
- `op_ready`  out  1  high only in FEED.
- `op_a`  in  DIM×BITS_AB  slice k of A, lane i = A[i][k].
- `op_b`  in  DIM×BITS_AB  slice k of B, lane j = B[k][j].
- `sa_en`  out  1  array enable; low freezes the array.
- `sa_WrEn`  out  1  accumulator row write.
- `sa_Crow`  out  $clog2(DIM)  selected array row.
- `sa_A`  out  DIM×BITS_AB  skewed A lanes to the array.
- `sa_B`  out  DIM×BITS_AB  skewed B lanes to the array.
- `sa_Cin`  out  DIM×BITS_C  write data; constant 0.
- `sa_Cout`  in  DIM×BITS_C  array row `sa_Crow`, combinational.
- `res_valid`  out  1  result row present.
- `res_ready`  in  1  consumer accepts a row.
- `res_row`  out  $clog2(DIM)  index of the presented row.
- `res_data`  out  DIM×BITS_C  equals `sa_Cout`.

## Operation
States: IDLE → CLEAR → FEED → FLUSH → DRAIN → IDLE. One counter `cnt` is shared by all states and is reset to 0 on each state entry.

- **IDLE.** All strobes are low. `start`=1 moves to CLEAR. `start` in any other state is ignored.
- **CLEAR** (DIM cycles).
  - Drives `sa_WrEn`=1, `sa_Crow`=`cnt`, `sa_Cin`=0, `sa_en`=0.
  - Leaves after `cnt`=DIM-1.
- **FEED.**
  - `op_ready`=1 and `sa_en`=`op_valid`; a beat is transferred when `op_valid`&&`op_ready`.
  - Skew: lane i of A is delayed DIM-1-i beats, and lane j of B is delayed DIM-1-j beats.
  - The delays are realised as shift registers that advance only when `sa_en`=1.
  - Lane DIM-1 has zero delay: it is passed through when the beat is valid and forced to 0 otherwise.
  - `op_valid`=0 stalls: `sa_en`=0, so the array and skew registers hold.
  - Leaves after the DIM-th accepted beat.
- **FLUSH** (2·DIM-2 cycles).
  - `sa_en`=1; zeros are shifted into every skew register.
  - Every MAC(i,j) has received all DIM products by the end of this phase.
- **DRAIN.**
  - `sa_Crow`=`res_row`=`cnt`, `res_valid`=1, `sa_en`=0.
  - `cnt` advances on `res_ready`. `res_valid` holds and the row is stable while `res_ready`=0.
  - After row DIM-1 is accepted, pulse `done` and return to IDLE.
- **Arithmetic.** C[i][j] = Σ_k A[i][k]·B[k][j]. Accumulation is signed and wraps modulo 2^BITS_C inside the array; this block never saturates.
- **Outside FEED/FLUSH,** `sa_A` and `sa_B` are 0.
- **Reset** (async, any state, including mid-job):
  - State IDLE; all counters and skew registers 0.
  - Outputs: `busy`=0, `done`=0, `op_ready`=0, `res_valid`=0, `sa_en`=0, `sa_WrEn`=0, `sa_Crow`=0, `res_row`=0; `sa_A`, `sa_B`, `sa_Cin` all 0.
  - An aborted job's accumulators are undefined; the next job's CLEAR zeroes them.

## Timing
- `start` is sampled at edge 0. CLEAR occupies cycles 1..DIM, with `busy` high from cycle 1.
- With no stalls:
  - FEED occupies DIM cycles;
  - FLUSH occupies 2·DIM-2 cycles;
  - DRAIN occupies DIM cycles.
  - Minimum job length is therefore 5·DIM-2 cycles from IDLE exit to `done`. For DIM=8 this is 38, with `done` high in cycle 39.
- `done` coincides with the first IDLE cycle. `busy`=0 in that cycle, and a `start` there is accepted.
- `op_ready` and `res_valid` depend only on state and never combinationally on `op_valid` or `res_ready`.
- `res_data` is combinational from `sa_Cout` and valid in the same cycle as `res_valid`.

## Test plan
- **All-ones, DIM=8.** A=all 1, B=all 1, no stalls → 8 rows, every element 8; `done` 38 cycles after the cycle following `start`.
- **Identity pass-through.** A=identity, B[k][j]=8k+j → row r equals {8r..8r+7}. Repeat back-to-back with `start` asserted in the `done` cycle; the second result must carry no residue from the first.
- **Wrap-around.** A=B=all 127, BITS_C=16 → every element = 129032 mod 2^16 = -2040 (signed).
- **Backpressure.** Random `op_valid` gaps (~50%) plus `res_ready` held low for 5 cycles on row 3 → results identical to the no-stall run; row 3 is held stable, then rows 4..7 follow.
- **Mid-job reset.** Assert `rst_n`=0 during FLUSH → all outputs at reset values immediately. Release and run a job with A=identity, B=all 2 → every element 2.
- **Ignored start / signed operands.** Pulse `start` during FEED → no effect. A=all -1, B=all 3 → every element -24.

Source files
------------

// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for one DIM x DIM output-stationary MAC array.
// Clears accumulators, feeds skewed operands, flushes, then drains rows.
module systolic_ctrl #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16,
  parameter int DIM     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  input  logic                      op_valid,
  output logic                      op_ready,
  input  logic [DIM*BITS_AB-1:0]    op_a,
  input  logic [DIM*BITS_AB-1:0]    op_b,
  output logic                      sa_en,
  output logic                      sa_WrEn,
  output logic [$clog2(DIM)-1:0]    sa_Crow,
  output logic [DIM*BITS_AB-1:0]    sa_A,
  output logic [DIM*BITS_AB-1:0]    sa_B,
  output logic [DIM*BITS_C-1:0]     sa_Cin,
  input  logic [DIM*BITS_C-1:0]     sa_Cout,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [$clog2(DIM)-1:0]    res_row,
  output logic [DIM*BITS_C-1:0]     res_data
);

  localparam int RW = $clog2(DIM);
  localparam int CW = $clog2(2*DIM);
  localparam logic [CW-1:0] ROW_LAST   = CW'(DIM-1);
  localparam logic [CW-1:0] FLUSH_LAST = CW'(2*DIM-3);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          feed, flush, rowsel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        if (cnt_q == ROW_LAST) begin
          state_d = FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FEED: begin
        if (op_valid) begin
          if (cnt_q == ROW_LAST) begin
            state_d = FLUSH;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == FLUSH_LAST) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (res_ready) begin
          if (cnt_q == ROW_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign feed   = (state_q == FEED);
  assign flush  = (state_q == FLUSH);
  assign rowsel = (state_q == CLEAR) || (state_q == DRAIN);

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign op_ready  = feed;
  assign sa_en     = (feed & op_valid) | flush;
  assign sa_WrEn   = (state_q == CLEAR);
  assign sa_Crow   = rowsel ? cnt_q[RW-1:0] : '0;
  assign sa_Cin    = '0;
  assign res_valid = (state_q == DRAIN);
  assign res_row   = res_valid ? cnt_q[RW-1:0] : '0;
  assign res_data  = sa_Cout;

  // Lane g is delayed DIM-1-g array steps; zeros enter during FLUSH.
  for (genvar g = 0; g < DIM-1; g++) begin : g_skew
    localparam int DEP = DIM-1-g;
    logic [BITS_AB-1:0] a_q [DEP];
    logic [BITS_AB-1:0] b_q [DEP];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < DEP; k++) begin
          a_q[k] <= '0;
          b_q[k] <= '0;
        end
      end else if (sa_en) begin
        a_q[0] <= feed ? op_a[g*BITS_AB +: BITS_AB] : '0;
        b_q[0] <= feed ? op_b[g*BITS_AB +: BITS_AB] : '0;
        for (int k = 1; k < DEP; k++) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
        end
      end
    end

    assign sa_A[g*BITS_AB +: BITS_AB] = (feed | flush) ? a_q[DEP-1] : '0;
    assign sa_B[g*BITS_AB +: BITS_AB] = (feed | flush) ? b_q[DEP-1] : '0;
  end

  assign sa_A[(DIM-1)*BITS_AB +: BITS_AB] =
    (feed & op_valid) ? op_a[(DIM-1)*BITS_AB +: BITS_AB] : '0;
  assign sa_B[(DIM-1)*BITS_AB +: BITS_AB] =
    (feed & op_valid) ? op_b[(DIM-1)*BITS_AB +: BITS_AB] : '0;

endmodule

// File: tb/tb_systolic_ctrl.sv
// tb_systolic_ctrl: drives jobs through systolic_ctrl with a MAC array model
// attached and checks every result against a plain matrix product.
module tb_systolic_ctrl;

  localparam int DIM = 8;
  localparam int BA  = 8;
  localparam int BC  = 16;
  localparam int RW  = $clog2(DIM);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              busy, done;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic [DIM*BA-1:0] op_a = '0;
  logic [DIM*BA-1:0] op_b = '0;
  logic              sa_en, sa_WrEn;
  logic [RW-1:0]     sa_Crow;
  logic [DIM*BA-1:0] sa_A, sa_B;
  logic [DIM*BC-1:0] sa_Cin;
  logic [DIM*BC-1:0] sa_Cout;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [RW-1:0]     res_row;
  logic [DIM*BC-1:0] res_data;

  systolic_ctrl #(.BITS_AB(BA), .BITS_C(BC), .DIM(DIM)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b),
    .sa_en(sa_en), .sa_WrEn(sa_WrEn), .sa_Crow(sa_Crow),
    .sa_A(sa_A), .sa_B(sa_B), .sa_Cin(sa_Cin), .sa_Cout(sa_Cout),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_row(res_row), .res_data(res_data)
  );

  always #5 clk = ~clk;

  // Array: A moves from column DIM-1 toward 0, B from row DIM-1 toward 0.
  logic signed [BA-1:0] ar  [DIM][DIM];
  logic signed [BA-1:0] br  [DIM][DIM];
  logic signed [BC-1:0] acc [DIM][DIM];
  logic signed [BA-1:0] ai, bi;
  int jn, in_;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          ar[i][j] <= '0;
          br[i][j] <= '0;
        end
    end else begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          jn  = (j == DIM-1) ? j : j + 1;
          in_ = (i == DIM-1) ? i : i + 1;
          ai = (j == DIM-1) ? $signed(sa_A[i*BA +: BA]) : ar[i][jn];
          bi = (i == DIM-1) ? $signed(sa_B[j*BA +: BA]) : br[in_][j];
          if (sa_en) begin
            ar[i][j]  <= ai;
            br[i][j]  <= bi;
            acc[i][j] <= acc[i][j] + BC'(ai * bi);
          end
        end
      if (sa_WrEn)
        for (int j = 0; j < DIM; j++)
          acc[sa_Crow][j] <= $signed(sa_Cin[j*BC +: BC]);
    end
  end

  always_comb begin
    sa_Cout = '0;
    for (int j = 0; j < DIM; j++)
      sa_Cout[j*BC +: BC] = acc[sa_Crow][j];
  end

  int ma [DIM][DIM];
  int mb [DIM][DIM];
  int ex [DIM][DIM];
  int got[DIM][DIM];
  int n_cmp = 0;
  int n_bad = 0;

  bit tmo;
  int done_cyc, order_bad, hold_seen, hold_chg;
  logic busy_first;

  function automatic int wrapc(input int s);
    logic signed [BC-1:0] w;
    w = BC'(s);
    return int'(w);
  endfunction

  task automatic ref_mm();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        int s = 0;
        for (int k = 0; k < DIM; k++) s += ma[i][k] * mb[k][j];
        ex[i][j] = wrapc(s);
      end
  endtask

  task automatic clr_got();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) got[i][j] = 99999;
  endtask

  task automatic set_rand();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = int'($urandom_range(255)) - 128;
        mb[i][j] = int'($urandom_range(255)) - 128;
      end
  endtask

  // Drives one job; abort_at>0 pulls reset low at that cycle instead.
  task automatic run_job(input bit started, input int vpct,
                         input int hrow, input int hlen,
                         input bit poke, input bit chain,
                         input int abort_at);
    int cyc, beat, row, held;
    bit have, ab;
    logic [DIM*BC-1:0] snap;
    tmo = 0; done_cyc = -1; order_bad = 0;
    hold_seen = 0; hold_chg = 0; busy_first = 1'b0;
    cyc = 0; beat = 0; row = 0; held = 0; have = 0; ab = 0;
    snap = '0;
    clr_got();
    if (!started) begin
      @(posedge clk); #1;
      start = 1'b1;
    end
    while (done_cyc < 0 && !tmo && !ab) begin
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (cyc == abort_at) begin
        rst_n = 1'b0;
        ab = 1;
      end else begin
        if (cyc == 1) busy_first = busy;
        op_valid = 1'b0;
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        if (op_ready && beat < DIM) begin
          op_valid = ($urandom_range(99) < vpct);
          if (op_valid)
            for (int l = 0; l < DIM; l++) begin
              op_a[l*BA +: BA] = BA'(ma[l][beat]);
              op_b[l*BA +: BA] = BA'(mb[beat][l]);
            end
        end
        if (poke && op_ready && beat == 2) start = 1'b1;
        res_ready = 1'b1;
        if (res_valid && row == hrow && held < hlen) begin
          res_ready = 1'b0;
          held++;
        end
        @(negedge clk);
        if (op_ready && op_valid) beat++;
        if (res_valid) begin
          if (int'(res_row) != row) order_bad++;
          if (row == hrow) begin
            if (!have) begin
              snap = res_data;
              have = 1;
            end else begin
              hold_seen++;
              if (res_data !== snap) hold_chg++;
            end
          end
          if (res_ready && row < DIM) begin
            for (int l = 0; l < DIM; l++)
              got[row][l] = int'($signed(res_data[l*BC +: BC]));
            row++;
          end
        end
        if (done) done_cyc = cyc;
        if (cyc > 2000) tmo = 1;
      end
    end
    op_valid = 1'b0;
    if (chain && !tmo && !ab) start = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({busy, done, op_ready, res_valid, sa_en, sa_WrEn} !== 6'b0) begin
      n_bad++;
      $display("FAIL reset_strobes got %b want 000000",
               {busy, done, op_ready, res_valid, sa_en, sa_WrEn});
    end
    n_cmp++;
    if ({sa_Crow, res_row, sa_A, sa_B, sa_Cin} !== '0) begin
      n_bad++;
      $display("FAIL reset_buses got %h/%h/%h/%h want all 0",
               sa_Crow, res_row, sa_A, sa_B);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_all_ones();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = 1;
        mb[i][j] = 1;
      end
    ref_mm();
    run_job(0, 100, -1, 0, 0, 0, 0);
    n_cmp++;
    if (tmo || done_cyc != 5*DIM-1) begin
      n_bad++;
      $display("FAIL ones_done_cycle got %0d want %0d", done_cyc, 5*DIM-1);
    end
    n_cmp++;
    if (busy_first !== 1'b1) begin
      n_bad++;
      $display("FAIL ones_busy_c1 got %b want 1", busy_first);
    end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        n_cmp++;
        if (got[i][j] !== 8) begin
          n_bad++;
          $display("FAIL ones C[%0d][%0d] got %0d want 8", i, j, got[i][j]);
        end
      end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 8*i + j;
      end
    ref_mm();
    for (int pass = 0; pass < 2; pass++) begin
      run_job(pass == 1, 100, -1, 0, 0, pass == 0, 0);
      n_cmp++;
      if (tmo || done_cyc != 5*DIM-1 || order_bad != 0) begin
        n_bad++;
        $display("FAIL b2b%0d_timing got done=%0d order_bad=%0d want %0d/0",
                 pass, done_cyc, order_bad, 5*DIM-1);
      end
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          n_cmp++;
          if (got[i][j] !== 8*i + j) begin
            n_bad++;
            $display("FAIL b2b%0d C[%0d][%0d] got %0d want %0d",
                     pass, i, j, got[i][j], 8*i + j);
          end
        end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = 127;
        mb[i][j] = 127;
      end
    ref_mm();
    run_job(0, 100, -1, 0, 0, 0, 0);
    n_cmp++;
    if (ex[0][0] !== -2040 || got[0][0] !== -2040) begin
      n_bad++;
      $display("FAIL wrap_const got %0d want -2040", got[0][0]);
    end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        n_cmp++;
        if (got[i][j] !== ex[i][j]) begin
          n_bad++;
          $display("FAIL wrap C[%0d][%0d] got %0d want %0d",
                   i, j, got[i][j], ex[i][j]);
        end
      end
  endtask

  task automatic test_backpressure();
    set_rand();
    ref_mm();
    run_job(0, 50, 3, 5, 0, 0, 0);
    n_cmp++;
    if (tmo || order_bad != 0 || hold_seen != 5 || hold_chg != 0) begin
      n_bad++;
      $display("FAIL bp_hold got tmo=%0d order=%0d seen=%0d chg=%0d want 0/0/5/0",
               tmo, order_bad, hold_seen, hold_chg);
    end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        n_cmp++;
        if (got[i][j] !== ex[i][j]) begin
          n_bad++;
          $display("FAIL bp C[%0d][%0d] got %0d want %0d",
                   i, j, got[i][j], ex[i][j]);
        end
      end
  endtask

  task automatic test_mid_reset();
    set_rand();
    run_job(0, 100, -1, 0, 0, 0, 2*DIM + 3);
    #1;
    n_cmp++;
    if ({busy, done, op_ready, res_valid, sa_en, sa_WrEn} !== 6'b0) begin
      n_bad++;
      $display("FAIL midrst_strobes got %b want 000000",
               {busy, done, op_ready, res_valid, sa_en, sa_WrEn});
    end
    n_cmp++;
    if ({sa_Crow, res_row, sa_A, sa_B, sa_Cin} !== '0) begin
      n_bad++;
      $display("FAIL midrst_buses got %h/%h/%h/%h want all 0",
               sa_Crow, res_row, sa_A, sa_B);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 2;
      end
    run_job(0, 100, -1, 0, 0, 0, 0);
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        n_cmp++;
        if (got[i][j] !== 2) begin
          n_bad++;
          $display("FAIL midrst C[%0d][%0d] got %0d want 2", i, j, got[i][j]);
        end
      end
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        ma[i][j] = -1;
        mb[i][j] = 3;
      end
    run_job(0, 100, -1, 0, 1, 0, 0);
    n_cmp++;
    if (tmo || done_cyc != 5*DIM-1) begin
      n_bad++;
      $display("FAIL poke_done_cycle got %0d want %0d", done_cyc, 5*DIM-1);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL poke_idle_after got busy=%b want 0", busy);
    end
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++) begin
        n_cmp++;
        if (got[i][j] !== -24) begin
          n_bad++;
          $display("FAIL signed C[%0d][%0d] got %0d want -24", i, j, got[i][j]);
        end
      end
  endtask

  task automatic test_random();
    for (int t = 0; t < 3; t++) begin
      set_rand();
      ref_mm();
      run_job(0, int'($urandom_range(100, 30)), int'($urandom_range(DIM-1)),
              int'($urandom_range(4)), 0, 0, 0);
      n_cmp++;
      if (tmo || order_bad != 0 || hold_chg != 0) begin
        n_bad++;
        $display("FAIL rnd%0d_flow got tmo=%0d order=%0d chg=%0d want 0/0/0",
                 t, tmo, order_bad, hold_chg);
      end
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) begin
          n_cmp++;
          if (got[i][j] !== ex[i][j]) begin
            n_bad++;
            $display("FAIL rnd%0d C[%0d][%0d] got %0d want %0d",
                     t, i, j, got[i][j], ex[i][j]);
          end
        end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_back_to_back();
    test_wrap();
    test_backpressure();
    test_mid_reset();
    test_ignored_start();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
